hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised data-hazard unit for the pipelined core, sitting between decode (ID) and the execute/memory/writeback stages. It records every in-flight register writer in a DEPTH-entry shift scoreboard and compares the decode-stage source registers against all entries. It then either stalls decode, or supplies forwarding selects with a load-use stall when forwarding is compiled in. It also honours pipeline freeze and flush, and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width; address 0 is hardwired zero, never a hazard.
- DEPTH, 3, number of writer stages tracked; entry 0 = EX, entry DEPTH-1 = WB. Legal range 1..8.
- CNT_W, 32, stall counter width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a real instruction.
- id_rs1_addr, id_rs2_addr  in  REG_ADDR_W  decode source registers.
- id_rs1_used, id_rs2_used  in  1  source actually read by the instruction.
- id_rd_addr  in  REG_ADDR_W  decode destination.
- id_reg_write  in  1  decode instruction writes rd.
- id_mem_read  in  1  decode instruction is a load.
- hold  in  1  external freeze (memory wait); scoreboard does not shift.
- flush  in  1  branch/jump redirect; the decode instruction is killed.
- stall  out  1  combinational; decode must hold, a bubble enters EX.
- fwd_rs1_sel, fwd_rs2_sel  out  4  combinational; 0 = register file, k = forward from entry k-1.
- stall_cycles  out  CNT_W  registered saturating count of stalled cycles.

## Operation
- Each entry holds {valid, rd, is_load}. An entry is a writer match for source s when valid, rd != 0, rd == s's address, and s is used. The is_load field is only consulted when HAZARD_FWD_EN is defined.
- Without forwarding, stall = id_valid & !flush & (any entry matches rs1 or rs2).
- With forwarding, stall = id_valid & !flush & (entry 0 matches and entry 0 is_load). The sel output is the lowest-index (youngest) matching entry + 1, or 0 if there is no match. Sel is also driven while stalled; consumers ignore it then.
- Shift on each clock when !hold: entry k+1 <= entry k.
- Entry 0 on a shift:
  - id_valid & !stall & !flush & id_reg_write: {1, id_rd_addr, id_mem_read}.
  - Otherwise a bubble {0, 0, 0}. A non-writing instruction also enters as a bubble.
- hold=1: all entries keep their value and the counter does not increment. stall is still computed.
- flush=1 forces stall=0 and a bubble into entry 0. Older entries are unaffected because they are already committed to complete.
- stall_cycles increments when stall & !hold, and saturates at all-ones.
- rst: all entries invalid, stall_cycles = 0. rst dominates hold and flush.

## Timing
- stall and the fwd_* selects are zero-latency combinational functions of the current inputs and scoreboard state. They carry no registered delay.
- A writer accepted at edge N occupies entry 0 during cycle N+1 and entry k during cycle N+1+k (absent hold). It leaves after entry DEPTH-1.
- The register file does not bypass internally, so a match in entry DEPTH-1 (WB) still stalls or forwards.
- Load-use without hold: exactly one stall cycle. Without forwarding, a back-to-back dependence stalls DEPTH cycles.
- Reset values: stall=0, fwd_rs1_sel=fwd_rs2_sel=0 (scoreboard empty), stall_cycles=0. Reset asserted mid-stall clears it on the next edge.
- Simultaneous hold and stall: state frozen, stall stays asserted, and the counter is unchanged.
- Counter at max with stall: holds max.

## Configuration
- HAZARD_FWD_EN defined: forwarding mode as above. Only a load in EX stalls, and the fwd_* selects are live.
- Undefined: pure interlock. Any match in any entry stalls, fwd_* are tied to 0, and is_load storage may be optimised away.

## Test plan
- Reset, then idle with id_valid=0 for 5 cycles -> stall=0, sels=0, stall_cycles=0.
- No FWD, DEPTH=3: issue x5 writer, then decode reading rs1=x5 -> stall=1 for 3 cycles, then 0; stall_cycles=3.
- FWD: load to x7, then decode with rs2=x7 -> 1-cycle stall, then fwd_rs2_sel=2. An ALU writer to x7 followed by a dependent instruction -> no stall, fwd_rs2_sel=1.
- FWD: x3 writers at entries 0 and 2, decode reads x3 -> fwd_rs1_sel=1 (youngest). A rd=x0 writer followed by a reader of x0 -> no stall, sel=0.
- Stall active, assert hold for 4 cycles -> stall held at 1, counter frozen, entries unchanged. Release -> resolves as if no hold.
- flush during a would-be stall -> stall=0 and a bubble enters EX. rst mid-stall -> stall=0, count=0 after the edge.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle for hazard_scoreboard: decode operands and pipeline controls in,
// stall / forward selects / stall counter out.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic                  id_rs1_used;
  logic                  id_rs2_used;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  hold;
  logic                  flush;
  logic                  stall;
  logic [3:0]            fwd_rs1_sel;
  logic [3:0]            fwd_rs2_sel;
  logic [CNT_W-1:0]      stall_cycles;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_reg_write, id_mem_read, hold, flush,
    input  stall, fwd_rs1_sel, fwd_rs2_sel, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
           id_rd_addr, id_reg_write, id_mem_read, hold, flush,
    output stall, fwd_rs1_sel, fwd_rs2_sel, stall_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Data-hazard scoreboard: DEPTH-entry shift register of in-flight writers (entry 0 = EX).
// Define HAZARD_FWD_EN for forwarding with load-use stall; otherwise pure interlock.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               rst,
  hazard_scoreboard_if.slave hz
);

  logic [DEPTH-1:0]      r_vld;
  logic [REG_ADDR_W-1:0] r_rd [DEPTH];
  logic [CNT_W-1:0]      r_cnt;

  logic [DEPTH-1:0] w_m1;
  logic [DEPTH-1:0] w_m2;
  logic             w_stall;
  logic             w_accept;
  logic [3:0]       w_sel1;
  logic [3:0]       w_sel2;

  always_comb begin
    w_m1 = '0;
    w_m2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_m1[k] = r_vld[k] && (r_rd[k] != '0) && (r_rd[k] == hz.id_rs1_addr) && hz.id_rs1_used;
      w_m2[k] = r_vld[k] && (r_rd[k] != '0) && (r_rd[k] == hz.id_rs2_addr) && hz.id_rs2_used;
    end
  end

`ifdef HAZARD_FWD_EN
  logic [DEPTH-1:0] r_ld;

  // Descending scan so the youngest (lowest-index) match wins.
  always_comb begin
    w_stall = hz.id_valid && !hz.flush && r_ld[0] && (w_m1[0] || w_m2[0]);
    w_sel1  = '0;
    w_sel2  = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (w_m1[k]) w_sel1 = 4'(k + 1);
      if (w_m2[k]) w_sel2 = 4'(k + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ld <= '0;
    end else if (!hz.hold) begin
      for (int k = DEPTH - 1; k > 0; k--) r_ld[k] <= r_ld[k-1];
      r_ld[0] <= w_accept && hz.id_mem_read;
    end
  end
`else
  logic w_unused_ld;
  assign w_unused_ld = hz.id_mem_read;

  always_comb begin
    w_stall = hz.id_valid && !hz.flush && ((|w_m1) || (|w_m2));
    w_sel1  = '0;
    w_sel2  = '0;
  end
`endif

  assign w_accept = hz.id_valid && !w_stall && !hz.flush && hz.id_reg_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < DEPTH; k++) r_rd[k] <= '0;
    end else if (!hz.hold) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_vld[k] <= r_vld[k-1];
        r_rd[k]  <= r_rd[k-1];
      end
      r_vld[0] <= w_accept;
      r_rd[0]  <= w_accept ? hz.id_rd_addr : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_stall && !hz.hold && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign hz.stall        = w_stall;
  assign hz.fwd_rs1_sel  = w_sel1;
  assign hz.fwd_rs2_sel  = w_sel2;
  assign hz.stall_cycles = r_cnt;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: directed vectors push expectations, negedge monitor checks.
module tb_hazard_scoreboard;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(.REG_ADDR_W(AW), .CNT_W(CW)) hz ();

  hazard_scoreboard #(.REG_ADDR_W(AW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    string         tag;
    logic          stall;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t          q[$];
  exp_t          e;
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] ec;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (hz.stall !== e.stall || hz.fwd_rs1_sel !== e.s1 ||
          hz.fwd_rs2_sel !== e.s2 || hz.stall_cycles !== e.cnt) begin
        n_err++;
        $display("FAIL %s: stall/sel1/sel2/cnt got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d",
                 e.tag, hz.stall, hz.fwd_rs1_sel, hz.fwd_rs2_sel, hz.stall_cycles,
                 e.stall, e.s1, e.s2, e.cnt);
      end
    end
  end

  task automatic drive(input logic v, input logic [AW-1:0] rs1, input logic u1,
                       input logic [AW-1:0] rs2, input logic u2, input logic [AW-1:0] rd,
                       input logic w, input logic ld, input logic h, input logic f);
    hz.id_valid     = v;
    hz.id_rs1_addr  = rs1;
    hz.id_rs1_used  = u1;
    hz.id_rs2_addr  = rs2;
    hz.id_rs2_used  = u2;
    hz.id_rd_addr   = rd;
    hz.id_reg_write = w;
    hz.id_mem_read  = ld;
    hz.hold         = h;
    hz.flush        = f;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step(input string tag, input logic es, input logic [3:0] e1,
                      input logic [3:0] e2, input logic [CW-1:0] ecnt);
    exp_t x;
    x.tag = tag; x.stall = es; x.s1 = e1; x.s2 = e2; x.cnt = ecnt;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    step("reset", 1'b0, 4'd0, 4'd0, '0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step("idle", 1'b0, 4'd0, 4'd0, '0);

`ifdef HAZARD_FWD_EN
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);  step("ld_x7", 0, 0, 0, 0);
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);  step("ldu_stall", 1, 0, 1, 0);
    step("ldu_fwd", 0, 0, 2, 1);
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);  step("alu_x7", 0, 0, 0, 1);
    drive(1, 0, 0, 7, 1, 0, 0, 0, 0, 0);  step("alu_fwd", 0, 0, 1, 1);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);  step("wr_x3_a", 0, 0, 0, 1);
    idle();                               step("gap", 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);  step("wr_x3_c", 0, 0, 0, 1);
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);  step("youngest", 0, 1, 0, 1);
    step("older", 0, 2, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0);  step("wr_x0", 0, 0, 0, 1);
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);  step("rd_x0", 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0);  step("ld_x9", 0, 0, 0, 1);
    drive(1, 0, 0, 9, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("hold", 1, 0, 1, 1);
    drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);  step("hold_rel", 1, 0, 1, 1);
    step("hold_fwd", 0, 0, 2, 2);
    drive(1, 0, 0, 0, 0, 10, 1, 1, 0, 0); step("ld_x10", 0, 0, 0, 2);
    drive(1, 10, 1, 0, 0, 11, 1, 0, 0, 1); step("flush", 0, 1, 0, 2);
    drive(1, 11, 1, 10, 1, 0, 0, 0, 0, 0); step("flush_bubble", 0, 0, 2, 2);
    drive(1, 0, 0, 0, 0, 13, 1, 1, 0, 0); step("ld_x13", 0, 0, 0, 2);
    drive(1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;                           step("rst_mid", 1, 1, 0, 2);
    rst = 1'b0;                           step("rst_after", 0, 0, 0, 0);
    ec = '0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 0, 0, 0, 0, 14, 1, 1, 0, 0); step("sat_ld", 0, 0, 0, ec);
      drive(1, 14, 1, 0, 0, 0, 0, 0, 0, 0); step("sat_stall", 1, 1, 0, ec);
      ec = sat_inc(ec);
      step("sat_go", 0, 2, 0, ec);
    end
`else
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);  step("wr_x5", 0, 0, 0, 0);
    drive(1, 5, 1, 0, 0, 6, 1, 0, 0, 0);
    step("raw_x5_s0", 1, 0, 0, 0);
    step("raw_x5_s1", 1, 0, 0, 1);
    step("raw_x5_s2", 1, 0, 0, 2);
    step("raw_x5_go", 0, 0, 0, 3);
    idle();
    for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 3);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);  step("wr_x9", 0, 0, 0, 3);
    drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);  step("raw_x9_s0", 1, 0, 0, 3);
    drive(1, 0, 0, 9, 1, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step("hold", 1, 0, 0, 4);
    drive(1, 0, 0, 9, 1, 0, 0, 0, 0, 0);
    step("raw_x9_s1", 1, 0, 0, 4);
    step("raw_x9_s2", 1, 0, 0, 5);
    step("raw_x9_go", 0, 0, 0, 6);
    drive(1, 0, 0, 0, 0, 10, 1, 0, 0, 0); step("wr_x10", 0, 0, 0, 6);
    drive(1, 10, 1, 0, 0, 11, 1, 0, 0, 1); step("flush", 0, 0, 0, 6);
    drive(1, 11, 1, 0, 0, 0, 0, 0, 0, 0); step("flush_bubble", 0, 0, 0, 6);
    drive(1, 0, 0, 0, 0, 12, 1, 0, 0, 0); step("wr_x12", 0, 0, 0, 6);
    drive(1, 12, 0, 0, 0, 0, 0, 0, 0, 0); step("unused_src", 0, 0, 0, 6);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);  step("wr_x0", 0, 0, 0, 6);
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);  step("rd_x0", 0, 0, 0, 6);
    drive(1, 0, 0, 0, 0, 13, 1, 0, 0, 0); step("wr_x13", 0, 0, 0, 6);
    drive(1, 13, 1, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;                           step("rst_mid", 1, 0, 0, 6);
    rst = 1'b0;                           step("rst_after", 0, 0, 0, 0);
    ec = '0;
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 0, 14, 1, 0, 0, 0); step("sat_wr", 0, 0, 0, ec);
      drive(1, 14, 1, 0, 0, 0, 0, 0, 0, 0);
      for (int j = 0; j < DEPTH; j++) begin
        step("sat_stall", 1, 0, 0, ec);
        ec = sat_inc(ec);
      end
      step("sat_go", 0, 0, 0, ec);
    end
`endif

    idle();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      n_err++;
      $display("FAIL drain: pending expectations got %0d want 0", q.size());
    end
    if (n_vec < 12) begin
      n_err++;
      $display("FAIL vec_count: applied got %0d want >= 12", n_vec);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
